prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded instruction word.
REQ-002 SHALL have parameter TIMEOUT, default 1000: maximum idle cycles between bytes while receiving.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_start  input  1  single-cycle pulse requesting a program load.
REQ-006 SHALL have port load_len  input  8  number of 32-bit words to load; sampled on load_start.
REQ-007 SHALL have port byte_in  input  8  serial program byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  32  instruction-memory byte address.
REQ-012 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-013 SHALL have port cpu_reset  output  1  active-low reset driven to the CPU; low holds the CPU in reset.
REQ-014 SHALL have port PCinit  output  32  CPU start address, constant BASE_ADDR.
REQ-015 SHALL have port busy  output  1  high in RECV or WRITE.
REQ-016 SHALL have port done  output  1  high in RUN.
REQ-017 SHALL have port err  output  1  high in ERR.

Function
REQ-018 SHALL implement FSM states IDLE, RECV, WRITE, RUN, ERR; all outputs are registered or decoded from state only.
REQ-019 IDLE: cpu_reset=0, byte_ready=0; load_start with load_len!=0 latches load_len, clears word_idx, byte_cnt and timeout counter, then enters RECV; load_start with load_len==0 enters RUN.
REQ-020 RECV: byte_ready=1; a byte is accepted iff byte_valid && byte_ready; accepted bytes shift into word register MSB-first (first byte -> bits[31:24]).
REQ-021 RECV: byte_cnt counts 0..3; on acceptance of the 4th byte, byte_cnt wraps to 0 and the next state is WRITE.
REQ-022 WRITE: lasts exactly one cycle; byte_ready=0, imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR + 4*word_idx (32-bit, modulo 2^32).
REQ-023 WRITE: word_idx increments; if the written word was index load_len-1 the next state is RUN, else RECV.
REQ-024 RUN: cpu_reset=1, done=1; load_start (any load_len) re-enters the IDLE load path of REQ-019 in the same cycle, driving cpu_reset=0 from the next cycle.
REQ-025 Timeout: counter increments each RECV cycle without an accepted byte, clears on acceptance; reaching TIMEOUT-1 enters ERR, regardless of byte_cnt.
REQ-026 ERR: err=1, cpu_reset=0, byte_ready=0; exits only on load_start, handled as in REQ-019.
REQ-027 load_start in RECV or WRITE SHALL be ignored.
REQ-028 imem_we SHALL never be high outside WRITE; imem_addr and imem_wdata hold their last values otherwise.
REQ-029 A byte_valid in the same cycle as the timeout expiry SHALL be accepted and SHALL clear the timeout (no ERR).

Reset
REQ-030 reset low SHALL immediately force IDLE, cpu_reset=0, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=done=err=0, all counters 0, from any state including mid-word.
REQ-031 PCinit SHALL equal BASE_ADDR at all times, including during reset.

Verification
REQ-032 load_len=2, bytes 12 34 56 78 AA BB CC DD back-to-back -> WRITE 0x12345678 @0x0, WRITE 0xAABBCCDD @0x4, then done=1, cpu_reset=1.
REQ-033 load_len=1, byte_valid gapped 3 idle cycles between bytes -> single write 0xDEADBEEF @BASE_ADDR, no ERR.
REQ-034 TIMEOUT=8, load_len=1, send 2 bytes then stop -> err=1 8 cycles after last byte, imem_we never asserted, cpu_reset=0.
REQ-035 load_len=0 with load_start in IDLE -> RUN next cycle, no writes, cpu_reset=1.
REQ-036 reset asserted after 2 of 4 bytes -> all outputs at reset values immediately; fresh load of 1 word writes correct word at BASE_ADDR.
REQ-037 load_start in RUN with load_len=1 -> cpu_reset low next cycle, reload overwrites word @BASE_ADDR, returns to RUN.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a program as a serial byte stream, packs it MSB-first
// into 32-bit words, writes them to instruction memory and then releases the
// CPU from reset. Holds the CPU in reset while loading and on a stalled stream.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  load_len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic [31:0] PCinit,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_RUN,
    S_ERR
  } state_e;

  // Last idle-cycle count before the stream is declared stalled.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;
  logic [31:0] next_word;

  // Next-state and datapath updates; the load path is shared by IDLE, RUN and ERR.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    accept     = (state_q == S_RECV) && byte_valid;
    next_word  = {word_q[23:0], byte_in};

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_start) begin
          if (load_len != 8'd0) begin
            len_d      = load_len;
            word_idx_d = 8'd0;
            byte_cnt_d = 2'd0;
            tmo_d      = 32'd0;
            state_d    = S_RECV;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RECV: begin
        // An arriving byte always wins over an expiring timeout.
        if (accept) begin
          word_d = next_word;
          tmo_d  = 32'd0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            wdata_d    = next_word;
            addr_d     = BASE_ADDR + {22'd0, word_idx_q, 2'b00};
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        if (word_idx_q == len_q - 8'd1) begin
          state_d = S_RUN;
        end else begin
          state_d = S_RECV;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= 8'd0;
      word_idx_q <= 8'd0;
      byte_cnt_q <= 2'd0;
      tmo_q      <= 32'd0;
      word_q     <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Outputs decoded purely from state or taken straight from registers.
  always_comb begin
    byte_ready = (state_q == S_RECV);
    imem_we    = (state_q == S_WRITE);
    busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    done       = (state_q == S_RUN);
    err        = (state_q == S_ERR);
    cpu_reset  = (state_q == S_RUN);
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    PCinit     = BASE_ADDR;
  end

endmodule
